// File: rtl/rv32i_exec_mem_unit.sv
// Execute/memory slice of the rv32i single-cycle core.
// Main control decoder, 32-bit ALU with operand-2 select, and a word-organised
// data BRAM that has an init write port and a debug read port.
//
// Ports:
//   clk, rst                       clock; asynchronous active-low reset
//   init_done                      0: BRAM written by init_*, 1: by the datapath
//   init_w_addr/_dat/_enb          initialisation write port (byte address)
//   opcode, func3, func7           instruction fields
//   rs1, rs2, imm                  operands (rs2 is also store data)
//   debug_addr                     debug byte address
//   alu_results, alu_zero          ALU result and zero flag
//   branch                         take branch/jump
//   imm_src, alu_ctrl, alu_src     immediate format, ALU op, operand-2 select
//   mem_read, mem_write, mem_2_reg load/store strobes, load-to-register
//   reg_write, wrt_back_src        regfile write enable and write-back select
//   second_u_type_add_src          1 = lui, 0 = auipc
//   mem_rdata, debug_data          BRAM read data and debug word
module rv32i_exec_mem_unit #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_done,
    input  logic [ADDR_WIDTH-1:0] init_w_addr,
    input  logic [DATA_WIDTH-1:0] init_w_dat,
    input  logic                  init_w_enb,
    input  logic [6:0]            opcode,
    input  logic [2:0]            func3,
    input  logic [6:0]            func7,
    input  logic [DATA_WIDTH-1:0] rs1,
    input  logic [DATA_WIDTH-1:0] rs2,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic [ADDR_WIDTH-1:0] debug_addr,
    output logic [DATA_WIDTH-1:0] alu_results,
    output logic                  alu_zero,
    output logic                  branch,
    output logic [2:0]            imm_src,
    output logic [3:0]            alu_ctrl,
    output logic                  alu_src,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  mem_2_reg,
    output logic                  reg_write,
    output logic [1:0]            wrt_back_src,
    output logic                  second_u_type_add_src,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] debug_data
);

    localparam int unsigned IDX_W = ADDR_WIDTH - 2;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] WB_MEM  = 2'b00;
    localparam logic [1:0] WB_ALU  = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_UTYP = 2'b11;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_e;

    // func3 -> ALU op for R/I arithmetic; subtraction only exists for R-type
    function automatic alu_op_e f3_op(input logic [2:0] f3, input logic alt,
                                      input logic allow_sub);
        alu_op_e op;
        case (f3)
            3'b000:  op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    alu_op_e alu_op;
    logic    is_jump;
    logic    is_cond_br;

    // Main control decoder; everything idles while reset is held
    always_comb begin
        alu_op                = ALU_ADD;
        imm_src               = IMM_I;
        alu_src               = 1'b0;
        mem_read              = 1'b0;
        mem_write             = 1'b0;
        mem_2_reg             = 1'b0;
        reg_write             = 1'b0;
        wrt_back_src          = WB_ALU;
        second_u_type_add_src = 1'b0;
        is_jump               = 1'b0;
        is_cond_br            = 1'b0;
        if (rst) begin
            case (opcode)
                OP_R: begin
                    alu_op    = f3_op(func3, func7[5], 1'b1);
                    reg_write = 1'b1;
                end
                OP_I: begin
                    alu_op    = f3_op(func3, func7[5], 1'b0);
                    alu_src   = 1'b1;
                    reg_write = 1'b1;
                end
                OP_LOAD: begin
                    alu_src      = 1'b1;
                    mem_read     = 1'b1;
                    mem_2_reg    = 1'b1;
                    reg_write    = 1'b1;
                    wrt_back_src = WB_MEM;
                end
                OP_STORE: begin
                    alu_src   = 1'b1;
                    imm_src   = IMM_S;
                    mem_write = 1'b1;
                end
                OP_BRANCH: begin
                    imm_src    = IMM_B;
                    is_cond_br = 1'b1;
                    case (func3)
                        3'b100, 3'b101: alu_op = ALU_SLT;
                        3'b110, 3'b111: alu_op = ALU_SLTU;
                        default:        alu_op = ALU_SUB;
                    endcase
                end
                OP_JAL: begin
                    is_jump      = 1'b1;
                    imm_src      = IMM_J;
                    reg_write    = 1'b1;
                    wrt_back_src = WB_PC4;
                end
                OP_JALR: begin
                    is_jump      = 1'b1;
                    alu_src      = 1'b1;
                    reg_write    = 1'b1;
                    wrt_back_src = WB_PC4;
                end
                OP_LUI: begin
                    imm_src               = IMM_U;
                    reg_write             = 1'b1;
                    wrt_back_src          = WB_UTYP;
                    second_u_type_add_src = 1'b1;
                end
                OP_AUIPC: begin
                    imm_src      = IMM_U;
                    reg_write    = 1'b1;
                    wrt_back_src = WB_UTYP;
                end
                default: ;
            endcase
        end
    end

    assign alu_ctrl = alu_op;

    logic [DATA_WIDTH-1:0] op_b;
    logic [4:0]            shamt;

    assign op_b  = alu_src ? imm : rs2;
    assign shamt = op_b[4:0];

    // ALU; codes outside the defined set produce zero
    always_comb begin
        alu_results = '0;
        case (alu_ctrl)
            ALU_ADD:  alu_results = rs1 + op_b;
            ALU_SUB:  alu_results = rs1 - op_b;
            ALU_AND:  alu_results = rs1 & op_b;
            ALU_OR:   alu_results = rs1 | op_b;
            ALU_XOR:  alu_results = rs1 ^ op_b;
            ALU_SLL:  alu_results = rs1 << shamt;
            ALU_SRL:  alu_results = rs1 >> shamt;
            ALU_SRA:  alu_results = DATA_WIDTH'($signed(rs1) >>> shamt);
            ALU_SLT:  alu_results = {{(DATA_WIDTH-1){1'b0}}, ($signed(rs1) < $signed(op_b))};
            ALU_SLTU: alu_results = {{(DATA_WIDTH-1){1'b0}}, (rs1 < op_b)};
            default:  alu_results = '0;
        endcase
    end

    assign alu_zero = (alu_results == '0);

    // Branch resolution: the less-than ops leave 1 (non-zero) when the
    // comparison holds, so blt/bltu take on !zero and bge/bgeu on zero.
    logic br_take_c;
    always_comb begin
        br_take_c = 1'b0;
        case (func3)
            3'b000:         br_take_c = alu_zero;
            3'b001:         br_take_c = ~alu_zero;
            3'b100, 3'b110: br_take_c = ~alu_zero;
            3'b101, 3'b111: br_take_c = alu_zero;
            default:        br_take_c = 1'b0;
        endcase
    end

    assign branch = is_jump | (is_cond_br & br_take_c);

    // Data BRAM; contents are deliberately not cleared by reset
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  wr_en_c;
    logic [IDX_W-1:0]      wr_idx_c;
    logic [DATA_WIDTH-1:0] wr_dat_c;
    logic [IDX_W-1:0]      rd_idx_c;
    logic [IDX_W-1:0]      dbg_idx_c;

    assign wr_en_c   = rst & (init_done ? mem_write : init_w_enb);
    assign wr_idx_c  = init_done ? alu_results[ADDR_WIDTH-1:2] : init_w_addr[ADDR_WIDTH-1:2];
    assign wr_dat_c  = init_done ? rs2 : init_w_dat;
    assign rd_idx_c  = alu_results[ADDR_WIDTH-1:2];
    assign dbg_idx_c = debug_addr[ADDR_WIDTH-1:2];

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[wr_idx_c] <= wr_dat_c;
        end
    end

    assign mem_rdata  = (rst && mem_read) ? mem_q[rd_idx_c] : '0;
    assign debug_data = mem_q[dbg_idx_c];

    // Address byte-offset bits and unused func7 bits carry no meaning here
    logic unused_bits;
    assign unused_bits = ^{func7[6], func7[4:0], alu_results[DATA_WIDTH-1:ADDR_WIDTH],
                           alu_results[1:0], init_w_addr[1:0], debug_addr[1:0]};

endmodule

// File: tb/tb_rv32i_exec_mem_unit.sv
module tb_rv32i_exec_mem_unit;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_UNK    = 7'b0001111;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_done;
    logic [9:0]  init_w_addr;
    logic [31:0] init_w_dat;
    logic        init_w_enb;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] rs1, rs2, imm;
    logic [9:0]  debug_addr;
    logic [31:0] alu_results;
    logic        alu_zero, branch;
    logic [2:0]  imm_src;
    logic [3:0]  alu_ctrl;
    logic        alu_src, mem_read, mem_write, mem_2_reg, reg_write;
    logic [1:0]  wrt_back_src;
    logic        second_u_type_add_src;
    logic [31:0] mem_rdata, debug_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [256];

    rv32i_exec_mem_unit dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .init_w_addr(init_w_addr), .init_w_dat(init_w_dat), .init_w_enb(init_w_enb),
        .opcode(opcode), .func3(func3), .func7(func7),
        .rs1(rs1), .rs2(rs2), .imm(imm), .debug_addr(debug_addr),
        .alu_results(alu_results), .alu_zero(alu_zero), .branch(branch),
        .imm_src(imm_src), .alu_ctrl(alu_ctrl), .alu_src(alu_src),
        .mem_read(mem_read), .mem_write(mem_write), .mem_2_reg(mem_2_reg),
        .reg_write(reg_write), .wrt_back_src(wrt_back_src),
        .second_u_type_add_src(second_u_type_add_src),
        .mem_rdata(mem_rdata), .debug_data(debug_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        opcode = op;
        func3  = f3;
        func7  = f7;
    endtask

    typedef struct packed {
        logic [31:0] res;
        logic        br;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [1:0]  wb;
    } exp_t;

    // Instruction-level semantics of the slice
    function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] im);
        exp_t e;
        logic [31:0] o;
        int unsigned sh;
        e = '{res: a + b, br: 1'b0, rw: 1'b0, mr: 1'b0, mw: 1'b0, wb: 2'b01};
        if (op == OP_R || op == OP_I) begin
            o  = (op == OP_R) ? b : im;
            sh = o % 32;
            e.rw = 1'b1;
            case (f3)
                3'd0: e.res = (op == OP_R && f7[5]) ? a - o : a + o;
                3'd1: e.res = a << sh;
                3'd2: e.res = ($signed(a) < $signed(o)) ? 32'd1 : 32'd0;
                3'd3: e.res = (a < o) ? 32'd1 : 32'd0;
                3'd4: e.res = a ^ o;
                3'd5: e.res = f7[5] ? 32'($signed(a) >>> sh) : a >> sh;
                3'd6: e.res = a | o;
                default: e.res = a & o;
            endcase
        end else if (op == OP_LOAD) begin
            e.res = a + im; e.rw = 1'b1; e.mr = 1'b1; e.wb = 2'b00;
        end else if (op == OP_STORE) begin
            e.res = a + im; e.mw = 1'b1;
        end else if (op == OP_BRANCH) begin
            case (f3)
                3'd0: begin e.res = a - b; e.br = (a == b); end
                3'd1: begin e.res = a - b; e.br = (a != b); end
                3'd4: begin e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; e.br = ($signed(a) < $signed(b)); end
                3'd5: begin e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; e.br = ($signed(a) >= $signed(b)); end
                3'd6: begin e.res = (a < b) ? 32'd1 : 32'd0; e.br = (a < b); end
                default: begin e.res = (a < b) ? 32'd1 : 32'd0; e.br = (a >= b); end
            endcase
        end
        return e;
    endfunction

    initial begin
        exp_t        e;
        logic [2:0]  br_f3 [6];
        logic [31:0] addr;
        int          cls;

        br_f3[0] = 3'd0; br_f3[1] = 3'd1; br_f3[2] = 3'd4;
        br_f3[3] = 3'd5; br_f3[4] = 3'd6; br_f3[5] = 3'd7;
        for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;

        // Reset: a load opcode must still produce idle strobes
        rst = 1'b0; init_done = 1'b0; init_w_addr = '0; init_w_dat = '0; init_w_enb = 1'b0;
        instr(OP_LOAD, 3'd2, 7'd0); rs1 = 32'h0; rs2 = 32'h0; imm = 32'h0; debug_addr = '0;
        #1;
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_reg_write", 32'(reg_write), 32'd0);
        chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        chk("rst_wb", 32'(wrt_back_src), 32'd1);
        chk("rst_rdata", mem_rdata, 32'd0);
        #1 rst = 1'b1;

        // Init load through the init port
        instr(OP_UNK, 3'd0, 7'd0);
        init_w_addr = 10'h000; init_w_dat = 32'h0000000F; init_w_enb = 1'b1;
        tick();
        init_w_addr = 10'h004; init_w_dat = 32'h00000005;
        tick();
        init_w_enb = 1'b0;
        model_mem[0] = 32'h0000000F; model_mem[1] = 32'h00000005;
        debug_addr = 10'h000; #1 chk("init_dbg0", debug_data, 32'h0000000F);
        debug_addr = 10'h004; #1 chk("init_dbg1", debug_data, 32'h00000005);
        chk("init_rdata_idle", mem_rdata, 32'd0);

        // I-ALU logic ops
        rs1 = 32'h0F; imm = 32'h05; rs2 = 32'h0;
        instr(OP_I, 3'b100, 7'd0); #1 chk("xori", alu_results, 32'h0A);
        chk("xori_ctl", {alu_src, reg_write, wrt_back_src, imm_src}, {1'b1, 1'b1, 2'b01, 3'b000});
        instr(OP_I, 3'b111, 7'd0); #1 chk("andi", alu_results, 32'h05);
        instr(OP_I, 3'b110, 7'd0); #1 chk("ori", alu_results, 32'h0F);

        // R-type
        rs1 = 32'h3F; rs2 = 32'h05; imm = 32'hFFFF_FFFF;
        instr(OP_R, 3'b000, 7'h00); #1 chk("add", alu_results, 32'h44);
        chk("add_src", 32'(alu_src), 32'd0);
        instr(OP_R, 3'b000, 7'h20); #1 chk("sub", alu_results, 32'h3A);
        rs1 = 32'h8000_0000; rs2 = 32'd4;
        instr(OP_R, 3'b101, 7'h20); #1 chk("sra", alu_results, 32'hF800_0000);
        instr(OP_R, 3'b101, 7'h00); #1 chk("srl", alu_results, 32'h0800_0000);
        rs1 = 32'hFFFF_FFFF; rs2 = 32'd1;
        instr(OP_R, 3'b010, 7'h00); #1 chk("slt", alu_results, 32'd1);
        instr(OP_R, 3'b011, 7'h00); #1 chk("sltu", alu_results, 32'd0);
        chk("sltu_zero", 32'(alu_zero), 32'd1);
        instr(OP_I, 3'b000, 7'h20); rs1 = 32'd10; imm = 32'd3;
        #1 chk("addi_no_sub", alu_results, 32'd13);

        // Store word 2 through the datapath
        init_done = 1'b1;
        instr(OP_STORE, 3'b010, 7'd0); rs1 = 32'h4; imm = 32'h4; rs2 = 32'hDEAD_BEEF;
        debug_addr = 10'h008;
        #1 chk("sw_addr", alu_results, 32'h8);
        chk("sw_ctl", {mem_write, reg_write, imm_src}, {1'b1, 1'b0, 3'b001});
        chk("sw_before_edge", debug_data, model_mem[2]);
        tick();
        model_mem[2] = 32'hDEAD_BEEF;
        chk("sw_after_edge", debug_data, 32'hDEAD_BEEF);

        // Load it back
        instr(OP_LOAD, 3'b010, 7'd0); rs1 = 32'h0; imm = 32'h8;
        #1 chk("lw_data", mem_rdata, 32'hDEAD_BEEF);
        chk("lw_ctl", {mem_read, mem_2_reg, wrt_back_src}, {1'b1, 1'b1, 2'b00});

        // Same-word write and read: old data until the edge
        init_done = 1'b0; init_w_addr = 10'h00B; init_w_dat = 32'h1234_5678; init_w_enb = 1'b1;
        #1 chk("rdw_old", mem_rdata, 32'hDEAD_BEEF);
        tick();
        init_w_enb = 1'b0; model_mem[2] = 32'h1234_5678;
        chk("rdw_new", mem_rdata, 32'h1234_5678);
        init_done = 1'b1;

        // Branches and jumps
        rs1 = 32'd7; rs2 = 32'd7; imm = 32'h10;
        instr(OP_BRANCH, 3'b000, 7'd0); #1 chk("beq_eq", 32'(branch), 32'd1);
        chk("br_ctl", {reg_write, imm_src, alu_src}, {1'b0, 3'b010, 1'b0});
        instr(OP_BRANCH, 3'b001, 7'd0); #1 chk("bne_eq", 32'(branch), 32'd0);
        rs1 = 32'hFFFF_FFFE; rs2 = 32'd3;
        instr(OP_BRANCH, 3'b100, 7'd0); #1 chk("blt", 32'(branch), 32'd1);
        rs1 = 32'd1; rs2 = 32'hFFFF_FFFF;
        instr(OP_BRANCH, 3'b111, 7'd0); #1 chk("bgeu", 32'(branch), 32'd0);
        instr(OP_JAL, 3'b000, 7'd0); #1 chk("jal", {branch, wrt_back_src, imm_src, reg_write}, {1'b1, 2'b10, 3'b011, 1'b1});
        rs1 = 32'h100; imm = 32'h24;
        instr(OP_JALR, 3'b000, 7'd0); #1 chk("jalr", {branch, wrt_back_src, alu_src}, {1'b1, 2'b10, 1'b1});
        chk("jalr_target", alu_results, 32'h124);

        // U-type
        instr(OP_LUI, 3'b000, 7'd0); #1 chk("lui", {wrt_back_src, second_u_type_add_src, imm_src, reg_write}, {2'b11, 1'b1, 3'b100, 1'b1});
        instr(OP_AUIPC, 3'b000, 7'd0); #1 chk("auipc", {wrt_back_src, second_u_type_add_src, reg_write}, {2'b11, 1'b0, 1'b1});

        // Reset asserted mid-store: no write, contents retained
        instr(OP_STORE, 3'b010, 7'd0); rs1 = 32'h0; imm = 32'h0; rs2 = 32'hAAAA_5555;
        debug_addr = 10'h000;
        rst = 1'b0;
        #1 chk("rst_sw_strobes", {mem_write, reg_write, mem_read, branch}, 32'd0);
        chk("rst_sw_alu_ctrl", 32'(alu_ctrl), 32'd0);
        tick();
        chk("rst_sw_kept", debug_data, 32'h0000_000F);
        rst = 1'b1;
        #1 chk("rst_release_sw", 32'(mem_write), 32'd1);
        instr(OP_UNK, 3'b000, 7'd0);
        #1 chk("unk_strobes", {mem_write, reg_write, mem_read, branch}, 32'd0);

        // Randomized instructions against the reference model
        for (int n = 0; n < 300; n++) begin
            cls = int'($urandom_range(0, 5));
            func7 = 7'h00;
            func3 = 3'($urandom_range(0, 7));
            case (cls)
                0: opcode = OP_R;
                1: opcode = OP_I;
                2: opcode = OP_LOAD;
                3: opcode = OP_STORE;
                4: begin opcode = OP_BRANCH; func3 = br_f3[$urandom_range(0, 5)]; end
                default: opcode = OP_UNK;
            endcase
            if ((cls <= 1) && (func3 == 3'd5 || (cls == 0 && func3 == 3'd0)))
                func7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            rs1 = $urandom; imm = $urandom;
            rs2 = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
            debug_addr = 10'($urandom);
            e = model(opcode, func3, func7, rs1, rs2, imm);
            addr = e.res;
            #1;
            if (cls != 5) chk("rnd_res", alu_results, e.res);
            chk("rnd_branch", 32'(branch), 32'(e.br));
            chk("rnd_strobes", {reg_write, mem_read, mem_write, wrt_back_src}, {e.rw, e.mr, e.mw, e.wb});
            chk("rnd_rdata", mem_rdata, e.mr ? model_mem[addr[9:2]] : 32'h0);
            chk("rnd_debug", debug_data, model_mem[debug_addr[9:2]]);
            tick();
            if (e.mw) model_mem[addr[9:2]] = rs2;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
